uart_tx_fifo: RTL

- Byte buffer and launch sequencer directly upstream of the UART transmitter.
- Accepts bytes from the host side into a synchronous FIFO.
- Feeds bytes to the transmitter one at a time through its data-valid/byte interface.
- Paces launches with the transmitter's active/done outputs so back-to-back bytes go out with no loss and no host-side busy polling.

---
 rtl/uart_tx_fifo.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo : host-side byte FIFO and launch sequencer feeding a UART TX.
// Revision 1.0
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Wr_DV,
  input  logic [7:0]            i_Wr_Byte,
  input  logic                  i_Flush,
  output logic                  o_Full,
  output logic                  o_Empty,
  output logic [DEPTH_LOG2:0]   o_Count,
  output logic                  o_Overflow,
  output logic                  o_Launch_Err,
  output logic                  o_TX_DV,
  output logic [7:0]            o_TX_Byte,
  input  logic                  i_TX_Active,
  input  logic                  i_TX_Done
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int TMO_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [DEPTH_LOG2:0] C_DEPTH    = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [TMO_W-1:0]    C_TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_LAUNCH      = 2'd1,
    S_WAIT_ACTIVE = 2'd2,
    S_WAIT_DONE   = 2'd3
  } state_t;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full_q, empty_q, ovf_q;
  logic                  w_wr_ok, w_ovf, w_pop;

  state_t                state_q;
  logic [TMO_W-1:0]      tmo_q;
  logic                  dv_q, err_q;
  logic [7:0]            byte_q;

  // Full/empty are registered, so both the write and pop decisions use the
  // pre-edge occupancy; a same-cycle pop never frees room for a write.
  always_comb begin
    w_wr_ok  = i_Wr_DV && !full_q && !i_Flush;
    w_ovf    = i_Wr_DV &&  full_q && !i_Flush;
    w_pop    = (state_q == S_IDLE) && !empty_q && !i_TX_Active && !i_Flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      if (w_wr_ok && !w_pop)      count_d = count_q + 1'b1;
      else if (!w_wr_ok && w_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == C_DEPTH);
      empty_q  <= (count_d == '0);
      ovf_q    <= w_ovf;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst && w_wr_ok) mem_q[wr_ptr_q] <= i_Wr_Byte;
  end

  // Launch sequencer; reset leaves the transmitter alone, and the IDLE gate
  // on i_TX_Active re-synchronises with any frame still in flight.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      byte_q  <= '0;
    end else begin
      dv_q  <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_pop) begin
            byte_q  <= mem_q[rd_ptr_q];
            dv_q    <= 1'b1;
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tmo_q   <= '0;
          state_q <= S_WAIT_ACTIVE;
        end
        S_WAIT_ACTIVE: begin
          if (i_TX_Active) begin
            state_q <= S_WAIT_DONE;
          end else if (tmo_q == C_TMO_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (tmo_q != '1) begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (i_TX_Done) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_Full       = full_q;
  assign o_Empty      = empty_q;
  assign o_Count      = count_q;
  assign o_Overflow   = ovf_q;
  assign o_Launch_Err = err_q;
  assign o_TX_DV      = dv_q;
  assign o_TX_Byte    = byte_q;

endmodule
`default_nettype wire
